serdes_deser_align: RTL

- Parametrised serial-to-parallel deserializer for the serdes path.
- Samples one serial bit per enabled clock into a WIDTH-bit window.
- Finds word alignment by hunting for a COMMA pattern and declares lock after N_LOCK consecutive aligned commas.
- Once locked, emits parallel words with a one-cycle valid strobe; drops lock after MAX_GAP consecutive non-comma words.

---
 rtl/serdes_pkg.sv | 22 ++
 rtl/serdes_shift_in.sv | 41 ++++
 rtl/serdes_deser_align.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/serdes_pkg.sv
// Shared definitions for the serdes deserializer/aligner.
//   state_t       : alignment FSM state encoding
//   DEFAULT_COMMA : default alignment pattern (K28.5-style 8'hBC)
//   cnt_width()   : bits needed for a saturating counter that must hold max_val
package serdes_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [7:0] DEFAULT_COMMA = 8'hBC;

    // Never returns less than one bit, so a counter with max_val==0 still exists.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serdes_shift_in.sv
// Serial-in shift register for the deserializer.
// Ports:
//   clk       : system clock, rising edge
//   reset_L   : synchronous active-low reset, clears the register
//   enb       : sample enable, register holds when low
//   data_in   : serial bit
//   next_sr   : register contents after shifting data_in in (combinational)
// MSB_FIRST=1 shifts toward the MSB so the first bit ends in the MSB;
// MSB_FIRST=0 shifts toward the LSB so the first bit ends in the LSB.
module serdes_shift_in
    import serdes_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             enb,
    input  logic             data_in,
    output logic [WIDTH-1:0] next_sr
);

    logic [WIDTH-1:0] sr;

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign next_sr = {sr[WIDTH-2:0], data_in};
        end else begin : g_lsb
            assign next_sr = {data_in, sr[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            sr <= '0;
        end else if (enb) begin
            sr <= next_sr;
        end
    end

endmodule

// File: rtl/serdes_deser_align.sv
// Serial-to-parallel deserializer with comma-based word alignment.
// Ports:
//   clk       : system clock, rising edge
//   reset_L   : synchronous active-low reset
//   enb       : sample enable for data_in
//   data_in   : serial bit
//   data_out  : last aligned word (registered)
//   valid_out : one-cycle pulse when data_out updates
//   comma_out : data_out equals COMMA, qualified by valid_out
//   active    : high while locked
// SEARCH hunts bit-by-bit for COMMA; LOCKING then checks that the next
// N_LOCK-1 word-aligned slots also hold COMMA; LOCKED emits words and
// falls back to SEARCH after MAX_GAP consecutive non-comma words.
module serdes_deser_align
    import serdes_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] COMMA     = WIDTH'(DEFAULT_COMMA),
    parameter int               N_LOCK    = 2,
    parameter int               MAX_GAP   = 16,
    parameter int               MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             enb,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             comma_out,
    output logic             active
);

    localparam int BW = $clog2(WIDTH);
    localparam int CW = cnt_width(N_LOCK);
    localparam int GW = cnt_width(MAX_GAP);

    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [CW-1:0] LOCK_CNT = CW'(N_LOCK);
    localparam logic [GW-1:0] GAP_LIM  = GW'(MAX_GAP);

    logic [WIDTH-1:0] word;

    state_t           state,     state_nxt;
    logic [BW-1:0]    bit_cnt,   bit_cnt_nxt;
    logic [CW-1:0]    comma_cnt, comma_cnt_nxt;
    logic [GW-1:0]    gap_cnt,   gap_cnt_nxt;
    logic [WIDTH-1:0] data_nxt;
    logic             valid_nxt, comma_out_nxt, active_nxt;

    logic             word_is_comma;
    logic [CW-1:0]    comma_inc;
    logic [GW-1:0]    gap_inc;

    serdes_shift_in #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_in (
        .clk     (clk),
        .reset_L (reset_L),
        .enb     (enb),
        .data_in (data_in),
        .next_sr (word)
    );

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state     <= SEARCH;
            bit_cnt   <= '0;
            comma_cnt <= '0;
            gap_cnt   <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            comma_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            comma_cnt <= comma_cnt_nxt;
            gap_cnt   <= gap_cnt_nxt;
            data_out  <= data_nxt;
            valid_out <= valid_nxt;
            comma_out <= comma_out_nxt;
            active    <= active_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        comma_cnt_nxt = comma_cnt;
        gap_cnt_nxt   = gap_cnt;
        data_nxt      = data_out;
        valid_nxt     = 1'b0;
        comma_out_nxt = comma_out;

        word_is_comma = (word == COMMA);
        comma_inc     = (comma_cnt == LOCK_CNT) ? comma_cnt : comma_cnt + CW'(1);
        gap_inc       = (&gap_cnt) ? gap_cnt : gap_cnt + GW'(1);

        if (enb) begin
            case (state)
                SEARCH: begin
                    // Any bit position may start a word while hunting.
                    if (word_is_comma) begin
                        bit_cnt_nxt   = '0;
                        comma_cnt_nxt = CW'(1);
                        gap_cnt_nxt   = '0;
                        state_nxt     = (N_LOCK == 1) ? LOCKED : LOCKING;
                    end
                end

                LOCKING: begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_nxt = '0;
                        if (word_is_comma) begin
                            comma_cnt_nxt = comma_inc;
                            if (comma_inc == LOCK_CNT) begin
                                state_nxt   = LOCKED;
                                gap_cnt_nxt = '0;
                            end
                        end else begin
                            comma_cnt_nxt = '0;
                            state_nxt     = SEARCH;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + BW'(1);
                    end
                end

                LOCKED: begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_nxt   = '0;
                        data_nxt      = word;
                        valid_nxt     = 1'b1;
                        comma_out_nxt = word_is_comma;
                        if (word_is_comma) begin
                            gap_cnt_nxt = '0;
                        end else begin
                            gap_cnt_nxt = gap_inc;
                            // The word that exhausts the gap budget is still emitted.
                            if ((MAX_GAP != 0) && (gap_inc == GAP_LIM)) begin
                                state_nxt     = SEARCH;
                                comma_cnt_nxt = '0;
                            end
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + BW'(1);
                    end
                end

                default: begin
                    state_nxt = SEARCH;
                end
            endcase
        end

        active_nxt = (state_nxt == LOCKED);
    end

endmodule
